// File: rtl/pipe_block_addsub.sv
// Block-pipelined add/subtract: one BLK-bit slice of the sum is resolved per stage, with the
// carry registered between stages and a single global advance enable for backpressure.
module pipe_block_addsub #(
  parameter int W   = 128,
  parameter int BLK = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         C_in,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] S,
  output logic         C_out,
  output logic         ovf
);

  localparam int BlkSafe = (BLK >= 1) ? BLK : 1;
  localparam int NB      = (BLK >= 1) ? (W / BlkSafe) : 1;
  localparam int Last    = NB - 1;

  if ((W < 1) || (BLK < 1) || ((W % BlkSafe) != 0)) begin : g_bad_cfg
    $error("pipe_block_addsub: W must be a positive multiple of BLK, and BLK >= 1");
  end

  // Level 0 holds the captured operand set; level k+1 holds the state after block k is summed.
  logic [NB:0]  vld_q, vld_d;
  logic [NB:0]  c_q, c_d;
  logic         sub_q [NB+1];
  logic         sub_d [NB+1];
  logic [W-1:0] a_q   [NB+1];
  logic [W-1:0] a_d   [NB+1];
  logic [W-1:0] b_q   [NB+1];
  logic [W-1:0] b_d   [NB+1];
  logic [W-1:0] s_q   [NB+1];
  logic [W-1:0] s_d   [NB+1];
  logic         ovf_q, ovf_d;
  logic [BLK:0] blk_sum [NB];
  logic         en;

  for (genvar k = 0; k < NB; k++) begin : g_stg
    logic [BLK-1:0] b_eff;
    assign b_eff      = b_q[k][k*BLK +: BLK] ^ {BLK{sub_q[k]}};
    assign blk_sum[k] = {1'b0, a_q[k][k*BLK +: BLK]} + {1'b0, b_eff}
                        + {{BLK{1'b0}}, c_q[k]};
  end

  // Carry into bit W-1 is recovered from the sum bit and the two operand bits at that position.
  assign ovf_d = (a_q[Last][W-1] ^ b_q[Last][W-1] ^ sub_q[Last] ^ blk_sum[Last][BLK-1])
                 ^ blk_sum[Last][BLK];

  always_comb begin
    vld_d    = {vld_q[NB-1:0], in_valid};
    c_d      = '0;
    c_d[0]   = C_in ^ sub;
    a_d[0]   = A;
    b_d[0]   = B;
    sub_d[0] = sub;
    s_d[0]   = '0;
    for (int k = 0; k < NB; k++) begin
      c_d[k+1]                  = blk_sum[k][BLK];
      a_d[k+1]                  = a_q[k];
      b_d[k+1]                  = b_q[k];
      sub_d[k+1]                = sub_q[k];
      s_d[k+1]                  = s_q[k];
      s_d[k+1][k*BLK +: BLK]    = blk_sum[k][BLK-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k <= NB; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        s_q[k]   <= '0;
        sub_q[k] <= 1'b0;
      end
    end else if (en) begin
      vld_q <= vld_d;
      c_q   <= c_d;
      ovf_q <= ovf_d;
      for (int k = 0; k <= NB; k++) begin
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
        s_q[k]   <= s_d[k];
        sub_q[k] <= sub_d[k];
      end
    end
  end

  assign en        = !vld_q[NB] || out_ready;
  assign in_ready  = en;
  assign out_valid = vld_q[NB];
  assign S         = s_q[NB];
  assign C_out     = c_q[NB];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipe_block_addsub.sv
// Self-checking bench for pipe_block_addsub (W=16, BLK=4): directed corner cases plus
// randomized streams scored against an arithmetic reference model.
module tb_pipe_block_addsub;

  localparam int W   = 16;
  localparam int BLK = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         C_in;
  logic         sb;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] S;
  logic         C_out;
  logic         ovf;

  always #5 clk = ~clk;

  pipe_block_addsub #(
    .W   (W),
    .BLK (BLK)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (a),
    .B         (b),
    .C_in      (C_in),
    .sub       (sb),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
    .C_out     (C_out),
    .ovf       (ovf)
  );

  int          n_total = 0;
  int          n_bad   = 0;
  int          n_out   = 0;
  logic [17:0] exp_q [$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Returns {ovf, carry_out, sum} from plain integer arithmetic.
  function automatic logic [17:0] ref_model(input logic [15:0] op_a, input logic [15:0] op_b,
                                            input logic cin, input logic is_sub);
    int          ua, ub, ur, sa, sbv, sr;
    logic [15:0] s;
    logic        co, ov;
    ua  = int'(op_a);
    ub  = int'(op_b);
    sa  = int'($signed(op_a));
    sbv = int'($signed(op_b));
    if (is_sub) begin
      ur = ua - ub - int'(cin);
      co = (ur >= 0);
      sr = sa - sbv - int'(cin);
    end else begin
      ur = ua + ub + int'(cin);
      co = (ur > 65535);
      sr = sa + sbv + int'(cin);
    end
    s  = ur[15:0];
    ov = (sr > 32767) || (sr < -32768);
    return {ov, co, s};
  endfunction

  function automatic logic [15:0] rand_operand();
    case ($urandom_range(0, 7))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h7FFF;
      3:       return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic drive_random();
    a    = rand_operand();
    b    = rand_operand();
    C_in = 1'($urandom_range(0, 1));
    sb   = 1'($urandom_range(0, 1));
  endtask

  // Scoreboard and output-hold monitor, sampled on the falling edge.
  logic [17:0] e_m;
  logic [15:0] hold_s;
  logic        hold_c, hold_o;
  logic        prev_stall = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check_eq("hold_valid", out_valid, 1);
          check_eq("hold_s", S, hold_s);
          check_eq("hold_c", C_out, hold_c);
          check_eq("hold_ovf", ovf, hold_o);
        end
        if (out_valid && out_ready) begin
          check_eq("sb_nonempty", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e_m = exp_q.pop_front();
            check_eq("sb_s", S, e_m[15:0]);
            check_eq("sb_c", C_out, e_m[16]);
            check_eq("sb_ovf", ovf, e_m[17]);
          end
          n_out++;
        end
        if (in_valid && in_ready) exp_q.push_back(ref_model(a, b, C_in, sb));
        prev_stall = out_valid && !out_ready;
        hold_s     = S;
        hold_c     = C_out;
        hold_o     = ovf;
      end
    end
  end

  task automatic send_dir(input string tag, input logic [15:0] op_a, input logic [15:0] op_b,
                          input logic cin, input logic is_sub, input logic [15:0] es,
                          input logic ec, input logic eo);
    int lat;
    @(posedge clk); #1;
    a         = op_a;
    b         = op_b;
    C_in      = cin;
    sb        = is_sub;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat      = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq({tag, "_lat"}, lat, 4);
    check_eq({tag, "_s"}, S, es);
    check_eq({tag, "_c"}, C_out, ec);
    check_eq({tag, "_ovf"}, ovf, eo);
    @(negedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int   sent, base_out, first_ov, run, seen;
    logic acc;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    C_in      = 1'b0;
    sb        = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_valid", out_valid, 0);
    check_eq("rst_s", S, 0);
    check_eq("rst_c", C_out, 0);
    check_eq("rst_ovf", ovf, 0);
    rst = 1'b0;
    #1;
    check_eq("rst_in_ready", in_ready, 1);

    send_dir("add_ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    send_dir("sub_neg",    16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    send_dir("sub_bin",    16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0);
    send_dir("ovf_add",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    send_dir("ovf_sub",    16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // Backpressure: six sets, consumer stalls for three cycles while results are pending.
    sent     = 0;
    acc      = 1'b0;
    base_out = n_out;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      if (acc) sent++;
      if (sent == 6 && (n_out - base_out) == 6) break;
      out_ready = !(c >= 5 && c < 8);
      if (acc || c == 0) drive_random();
      in_valid = (sent < 6);
      #1;
      acc = in_valid && in_ready;
      if (out_valid && !out_ready) check_eq("bp_in_ready", in_ready, 0);
    end
    check_eq("bp_count", n_out - base_out, 6);
    in_valid  = 1'b0;
    out_ready = 1'b1;

    // Reset with two sets in flight.
    @(posedge clk); #1;
    drive_random();
    in_valid = 1'b1;
    @(posedge clk); #1;
    drive_random();
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk); #1;
    check_eq("rstmid_valid", out_valid, 0);
    check_eq("rstmid_s", S, 0);
    rst      = 1'b0;
    seen     = 0;
    base_out = n_out;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1;
    end
    check_eq("rstmid_none", seen, 0);
    check_eq("rstmid_nout", n_out - base_out, 0);
    send_dir("rst_after", 16'h1234, 16'h0FF0, 1'b1, 1'b0, 16'h2225, 1'b0, 1'b0);

    // Throughput: 20 back-to-back sets.
    first_ov  = -1;
    run       = 0;
    out_ready = 1'b1;
    base_out  = n_out;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        if (first_ov < 0) first_ov = c;
        if (c == first_ov + run) run++;
      end
      in_valid = (c < 20);
      drive_random();
    end
    check_eq("tput_first", first_ov, 5);
    check_eq("tput_run", run, 20);
    check_eq("tput_count", n_out - base_out, 20);

    // Random soak with random valid and ready.
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      drive_random();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk); #1;
    check_eq("drain_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
